// File: rtl/snes_pad_reader_pkg.sv
// -----------------------------------------------------------------------------
// snes_pad_reader_pkg
// Shared definitions for the SNES controller reader: the poll FSM state
// encoding, the serial bit positions of the buttons used by the game, and
// counter widths.
// -----------------------------------------------------------------------------
package snes_pad_reader_pkg;

  // Poll sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Position of each button in the 16-bit serial word (bit 0 shifts out first).
  localparam int unsigned SNES_SELECT = 2;
  localparam int unsigned SNES_START  = 3;
  localparam int unsigned SNES_UP     = 4;
  localparam int unsigned SNES_DOWN   = 5;
  localparam int unsigned SNES_LEFT   = 6;
  localparam int unsigned SNES_RIGHT  = 7;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_BITS = 16;

endpackage

// File: rtl/snes_pad_reader_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears both flops
//   i_d    - asynchronous input
//   o_q    - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/snes_pad_reader.sv
// -----------------------------------------------------------------------------
// snes_pad_reader
// Polls an SNES controller once per video frame and presents held button
// levels for the game.
//
// Parameters:
//   CLK_DIV      - pad-clock phase length in clk cycles (legal 4..1023)
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   i_frame      - frame strobe (vsync); a poll starts on its rising edge
//   i_pad_data   - serial pad data, asynchronous, 0 = pressed
//   o_pad_latch  - pad latch, active high
//   o_pad_clk    - pad shift clock, idles high
//   o_up/o_down/o_left/o_right - direction levels, 1 = pressed
//   o_pause      - Start button level
//   o_restart    - Select button level
//   o_present    - a controller answered the last completed poll
//   o_valid      - one-cycle pulse while the outputs take new values
//   o_dbg_state  - current poll FSM state
//
// Handshake: o_valid is a single-cycle strobe with no ready; it is high only
// in the DONE cycle, and every result output carries its new value in that
// same cycle and holds it until the next DONE.
// -----------------------------------------------------------------------------
module snes_pad_reader #(
  parameter int unsigned CLK_DIV = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame,
  input  logic       i_pad_data,
  output logic       o_pad_latch,
  output logic       o_pad_clk,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic       o_pause,
  output logic       o_restart,
  output logic       o_present,
  output logic       o_valid,
  output logic [2:0] o_dbg_state
);

  import snes_pad_reader_pkg::*;

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_half;
  logic [IDX_W-1:0]     r_idx;
  logic [NUM_BITS-1:0]  r_raw;
  logic                 r_frame;
  logic                 r_armed;

  logic r_up, r_down, r_left, r_right, r_pause, r_restart, r_present, r_valid;

  logic                w_pad_sync;
  logic                w_phase_end;
  logic                w_frame_rise;
  logic                w_sample;
  logic                w_to_done;
  logic                w_pad_latch;
  logic                w_pad_clk;
  logic [NUM_BITS-1:0] w_raw_final;
  logic                w_present;

  sync2 u_pad_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_pad_data),
    .o_q   (w_pad_sync)
  );

  assign w_phase_end = (r_cnt == PHASE_LAST);
  // r_armed stays low after reset until i_frame has been seen low, so a strobe
  // that was already high when reset released cannot start a poll.
  assign w_frame_rise = i_frame & ~r_frame & r_armed;

  // Next state and pad pin levels.
  always_comb begin
    w_state_nxt = r_state;
    w_pad_latch = 1'b0;
    w_pad_clk   = 1'b1;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_rise) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_pad_latch = 1'b1;
        // Latch is two phases long; r_half marks the second one.
        if (w_phase_end && r_half) w_state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (w_phase_end) begin
          w_sample    = 1'b1;
          w_state_nxt = (r_idx == IDX_W'(NUM_BITS - 1)) ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        w_pad_clk = 1'b0;
        if (w_phase_end) w_state_nxt = ST_HIGH;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_to_done = (r_state == ST_HIGH) && (w_state_nxt == ST_DONE);

  // The last bit is being sampled in the same cycle the results are loaded,
  // so bit 15 comes straight from the synchronizer.
  assign w_raw_final = {w_pad_sync, r_raw[NUM_BITS-2:0]};
  assign w_present   = &w_raw_final[NUM_BITS-1:NUM_BITS-4];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Phase counter, bit index, raw shift capture and frame edge tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_half  <= 1'b0;
      r_idx   <= '0;
      r_raw   <= '0;
      r_frame <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_frame <= i_frame;
      if (!i_frame) r_armed <= 1'b1;

      if (w_state_nxt != r_state || r_state == ST_IDLE || r_state == ST_DONE) begin
        r_cnt  <= '0;
        r_half <= 1'b0;
      end else if (w_phase_end) begin
        r_cnt  <= '0;
        r_half <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == ST_IDLE)                     r_idx <= '0;
      else if (r_state == ST_LOW && w_phase_end)  r_idx <= r_idx + IDX_W'(1);

      if (w_sample) r_raw[r_idx] <= w_pad_sync;
    end
  end

  // Result registers: all load together on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_pause   <= 1'b0;
      r_restart <= 1'b0;
      r_present <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_to_done;
      if (w_to_done) begin
        // An absent pad reads all zeros, which would look like every button
        // held; gating with presence reports nothing pressed instead.
        r_present <= w_present;
        r_up      <= w_present & ~w_raw_final[SNES_UP];
        r_down    <= w_present & ~w_raw_final[SNES_DOWN];
        r_left    <= w_present & ~w_raw_final[SNES_LEFT];
        r_right   <= w_present & ~w_raw_final[SNES_RIGHT];
        r_pause   <= w_present & ~w_raw_final[SNES_START];
        r_restart <= w_present & ~w_raw_final[SNES_SELECT];
      end
    end
  end

  assign o_pad_latch = w_pad_latch;
  assign o_pad_clk   = w_pad_clk;
  assign o_up        = r_up;
  assign o_down      = r_down;
  assign o_left      = r_left;
  assign o_right     = r_right;
  assign o_pause     = r_pause;
  assign o_restart   = r_restart;
  assign o_present   = r_present;
  assign o_valid     = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_snes_pad_reader.sv
// -----------------------------------------------------------------------------
// tb_snes_pad_reader
// Directed bench for snes_pad_reader with CLK_DIV=4. A behavioural pad drives
// the serial data from a 16-bit pattern; expected results are pushed into a
// queue when a poll is launched and a monitor pops them on each o_valid.
// Result vector order: {present, up, down, left, right, pause, restart}.
// -----------------------------------------------------------------------------
module tb_snes_pad_reader;

  localparam int unsigned CLK_DIV = 4;
  localparam int W = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_frame = 1'b0;
  logic i_pad_data = 1'b0;

  logic o_pad_latch, o_pad_clk;
  logic o_up, o_down, o_left, o_right, o_pause, o_restart, o_present, o_valid;
  logic [2:0] o_dbg_state;

  always #5 clk = ~clk;

  snes_pad_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame     (i_frame),
    .i_pad_data  (i_pad_data),
    .o_pad_latch (o_pad_latch),
    .o_pad_clk   (o_pad_clk),
    .o_up        (o_up),
    .o_down      (o_down),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_pause     (o_pause),
    .o_restart   (o_restart),
    .o_present   (o_present),
    .o_valid     (o_valid),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  logic [W-1:0] mon_exp;
  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_pushed = 0;

  function automatic logic [W-1:0] outs();
    return {o_present, o_up, o_down, o_left, o_right, o_pause, o_restart};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pad model ----------------
  // Latch loads bit 0 onto the line; each rising pad clock shifts the next bit.
  logic [15:0] pad_pat = 16'h0000;
  int pad_idx = 0;

  always @(posedge o_pad_latch or posedge o_pad_clk) begin
    if (o_pad_latch) begin
      pad_idx = 0;
      i_pad_data = pad_pat[0];
    end else if (rst_n === 1'b1 && pad_idx < 15) begin
      pad_idx++;
      i_pad_data = pad_pat[pad_idx];
    end
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got o_valid=1 with outputs %0h, expected no pulse at %0t", outs(), $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("poll_result", {25'd0, outs()}, {25'd0, mon_exp});
      end
    end
  end

  // ---------------- pad timing monitor ----------------
  int lat_len = 0, low_len = 0, n_low = 0, since_latch = 0, n_latch_rise = 0;
  logic prev_latch = 1'b0, prev_clk = 1'b1, in_poll = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lat_len = 0; low_len = 0; n_low = 0; in_poll = 1'b0;
      prev_latch = 1'b0; prev_clk = 1'b1;
    end else begin
      if (o_pad_latch && !prev_latch) begin
        in_poll = 1'b1; since_latch = 0; n_low = 0; lat_len = 0; n_latch_rise++;
      end else if (in_poll) begin
        since_latch++;
      end
      if (o_pad_latch) lat_len++;
      if (!o_pad_latch && prev_latch) check("latch_len", lat_len, 2 * CLK_DIV);
      if (!o_pad_clk) low_len++;
      if (o_pad_clk && !prev_clk) begin
        check("low_len", low_len, CLK_DIV);
        n_low++;
      end
      if (o_pad_clk) low_len = 0;
      if (o_valid && in_poll) begin
        check("valid_latency", since_latch, 33 * CLK_DIV);
        check("low_pulses", n_low, 15);
        in_poll = 1'b0;
      end
      prev_latch = o_pad_latch;
      prev_clk = o_pad_clk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frame_edge();
    @(negedge clk) i_frame = 1'b0;
    repeat (2) @(negedge clk);
    i_frame = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_poll(input logic [15:0] raw, input logic [W-1:0] exp);
    pad_pat = raw;
    exp_q.push_back(exp);
    n_pushed++;
    frame_edge();
    repeat (60) @(negedge clk);
    check("hold_prev", {25'd0, outs()}, {25'd0, last_exp});
    wait_drain("poll_done");
    repeat (3) @(negedge clk);
    check("hold_after", {25'd0, outs()}, {25'd0, exp});
    last_exp = exp;
  endtask

  // ---------------- main sequence ----------------
  int v0, r0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_latch", o_pad_latch, 1'b0);
    check("rst_padclk", o_pad_clk, 1'b1);
    check("rst_outs", {25'd0, outs()}, 32'd0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_state", o_dbg_state, 3'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Button map, presence and opposing directions
    run_poll(16'hFFEF, 7'b1100000);  // up
    run_poll(16'hFFF3, 7'b1000011);  // start + select
    run_poll(16'h0000, 7'b0000000);  // absent
    run_poll(16'hFF0F, 7'b1111100);  // all four directions
    run_poll(16'h7FEF, 7'b0000000);  // top id bit low -> absent, up masked
    run_poll(16'hFFDF, 7'b1010000);  // down
    run_poll(16'hFFBF, 7'b1001000);  // left
    run_poll(16'hFFFB, 7'b1000001);  // select only
    run_poll(16'hFFF7, 7'b1000010);  // start only

    // Busy: second frame edge 20 cycles into a poll is dropped
    v0 = n_valid;
    pad_pat = 16'hFF7F;
    exp_q.push_back(7'b1000100);
    n_pushed++;
    frame_edge();
    repeat (20) @(negedge clk);
    i_frame = 1'b0;
    repeat (2) @(negedge clk);
    i_frame = 1'b1;
    wait_drain("busy_done");
    repeat (200) @(negedge clk);
    check("busy_one_valid", n_valid - v0, 1);
    check("busy_hold", {25'd0, outs()}, {25'd0, 7'b1000100});
    last_exp = 7'b1000100;

    // Reset mid-poll: aborts with no result, outputs cleared immediately
    pad_pat = 16'hFFF3;
    frame_edge();
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_latch", o_pad_latch, 1'b0);
    check("midrst_padclk", o_pad_clk, 1'b1);
    check("midrst_outs", {25'd0, outs()}, 32'd0);
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_state", o_dbg_state, 3'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    last_exp = '0;
    // i_frame stayed high across reset: no poll may start
    r0 = n_latch_rise;
    repeat (200) @(negedge clk);
    check("no_poll_after_rst", n_latch_rise - r0, 0);
    check("idle_after_rst", o_dbg_state, 3'd0);

    // A fresh edge polls again
    run_poll(16'hFFF3, 7'b1000011);

    check("valid_count", n_valid, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
